// File: rtl/dmd_video_capture.sv
// Receives a DE/hsync/vsync/RGB stream and writes one sample per CELLxCELL block to the DMD frame RAM.
// Optional frame signature enabled by defining DMD_CAPTURE_SIG_EN.
module dmd_video_capture #(
    parameter int H_CELLS    = 128,
    parameter int V_CELLS    = 39,
    parameter int CELL       = 10,
    parameter int SAMPLE_OFS = 5,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 390
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        locked,
    output logic [23:0] frame_sig
);

    localparam int          SW        = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);
    localparam logic [SW-1:0] SUB_OFS  = SW'(SAMPLE_OFS);
    localparam logic [SW-1:0] SUB_ONE  = SW'(1);
    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam logic [11:0] H_CELLS12 = 12'(H_CELLS);
    localparam logic [11:0] V_CELLS12 = 12'(V_CELLS);
    localparam logic [11:0] H_ACT12   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT12   = 12'(V_ACTIVE);
    localparam logic [12:0] H_CELLS13 = 13'(H_CELLS);

    typedef enum logic [0:0] {WAIT_VS = 1'b0, CAPTURE = 1'b1} state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

    state_t        state_r;
    logic          de_q_r, de_prev_r, vs_q_r, vs_prev_r, hs_q_unused_r;
    logic [23:0]   rgb_q_r;
    logic [SW-1:0] sub_x_r, sub_y_r, sub_x_e_s, sub_y_e_s;
    logic [11:0]   cell_x_r, cell_y_r, pix_cnt_r, line_cnt_r;
    logic [11:0]   cell_x_e_s, cell_y_e_s, pix_e_s, line_end_s;
    logic          len_err_r, len_err_end_s, frame_good_s;
    logic          vs_rise_s, de_fall_s, wr_cond_s;
    logic [12:0]   wr_addr_s;
    logic          wr_en_r, frame_done_r, frame_ok_r, locked_r;
    logic [12:0]   wr_addr_r;
    logic [23:0]   wr_data_r;

    // Stage 0: register every input pin; hsync is kept only for alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q_r        <= 1'b0;
            de_prev_r     <= 1'b0;
            vs_q_r        <= 1'b0;
            vs_prev_r     <= 1'b0;
            hs_q_unused_r <= 1'b0;
            rgb_q_r       <= 24'h000000;
        end else begin
            de_q_r        <= de;
            de_prev_r     <= de_q_r;
            vs_q_r        <= vsync;
            vs_prev_r     <= vs_q_r;
            hs_q_unused_r <= hsync;
            rgb_q_r       <= {red, green, blue};
        end
    end

    // Effective counter values: a vs_rise restarts the frame in this very cycle
    always_comb begin
        vs_rise_s = vs_q_r & ~vs_prev_r;
        de_fall_s = ~de_q_r & de_prev_r;
        if (vs_rise_s) begin
            sub_x_e_s  = '0;
            sub_y_e_s  = '0;
            cell_x_e_s = 12'd0;
            cell_y_e_s = 12'd0;
            pix_e_s    = 12'd0;
        end else begin
            sub_x_e_s  = sub_x_r;
            sub_y_e_s  = sub_y_r;
            cell_x_e_s = cell_x_r;
            cell_y_e_s = cell_y_r;
            pix_e_s    = pix_cnt_r;
        end
        line_end_s    = de_fall_s ? sat_inc(line_cnt_r) : line_cnt_r;
        len_err_end_s = len_err_r | (de_fall_s & (pix_cnt_r != H_ACT12));
        frame_good_s  = (line_end_s == V_ACT12) && !len_err_end_s;
        wr_cond_s = (state_r == CAPTURE) && de_q_r && (sub_x_e_s == SUB_OFS) &&
                    (sub_y_e_s == SUB_OFS) && (cell_x_e_s < H_CELLS12) &&
                    (cell_y_e_s < V_CELLS12);
        wr_addr_s = 13'(cell_y_e_s) * H_CELLS13 + 13'(cell_x_e_s);
    end

    // Column counters follow de_q; row counters and length check follow de_fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x_r    <= '0;
            cell_x_r   <= 12'd0;
            pix_cnt_r  <= 12'd0;
            sub_y_r    <= '0;
            cell_y_r   <= 12'd0;
            line_cnt_r <= 12'd0;
            len_err_r  <= 1'b0;
        end else begin
            if (de_q_r) begin
                pix_cnt_r <= sat_inc(pix_e_s);
                if (sub_x_e_s == SUB_LAST) begin
                    sub_x_r  <= '0;
                    cell_x_r <= sat_inc(cell_x_e_s);
                end else begin
                    sub_x_r  <= sub_x_e_s + SUB_ONE;
                    cell_x_r <= cell_x_e_s;
                end
            end else begin
                sub_x_r   <= '0;
                cell_x_r  <= 12'd0;
                pix_cnt_r <= 12'd0;
            end
            if (vs_rise_s) begin
                sub_y_r    <= '0;
                cell_y_r   <= 12'd0;
                line_cnt_r <= 12'd0;
                len_err_r  <= 1'b0;
            end else if (de_fall_s) begin
                line_cnt_r <= sat_inc(line_cnt_r);
                len_err_r  <= len_err_end_s;
                if (sub_y_r == SUB_LAST) begin
                    sub_y_r  <= '0;
                    cell_y_r <= sat_inc(cell_y_r);
                end else begin
                    sub_y_r <= sub_y_r + SUB_ONE;
                end
            end
        end
    end

    // Capture FSM with registered write and frame-status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= WAIT_VS;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 13'd0;
            wr_data_r    <= 24'h000000;
            frame_done_r <= 1'b0;
            frame_ok_r   <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            wr_en_r      <= wr_cond_s;
            frame_done_r <= 1'b0;
            if (wr_cond_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= rgb_q_r;
            end
            case (state_r)
                WAIT_VS: begin
                    if (vs_rise_s) state_r <= CAPTURE;
                end
                CAPTURE: begin
                    if (vs_rise_s) begin
                        frame_done_r <= 1'b1;
                        frame_ok_r   <= frame_good_s;
                        locked_r     <= frame_good_s;
                    end
                end
                default: state_r <= WAIT_VS;
            endcase
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign frame_ok   = frame_ok_r;
    assign locked     = locked_r;

`ifdef DMD_CAPTURE_SIG_EN
    logic [23:0] sig_acc_r, frame_sig_r;

    // XOR of every written word, latched when a captured frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_acc_r   <= 24'h000000;
            frame_sig_r <= 24'h000000;
        end else if (vs_rise_s) begin
            if (state_r == CAPTURE) frame_sig_r <= sig_acc_r;
            sig_acc_r <= 24'h000000;
        end else if (wr_cond_s) begin
            sig_acc_r <= sig_acc_r ^ rgb_q_r;
        end
    end

    assign frame_sig = frame_sig_r;
`else
    assign frame_sig = 24'h000000;
`endif

endmodule

// File: tb/tb_dmd_video_capture.sv
// Directed bench for dmd_video_capture on a scaled-down geometry (8x4 cells of 4x4 pixels, sample offset 3).
module tb_dmd_video_capture;

    localparam int HC = 8, VC = 4, CL = 4, OFS = 3, HA = 32, VA = 16;

    logic        clk, rst_n, de, hsync, vsync;
    logic [7:0]  red, green, blue;
    logic        wr_en, frame_done, frame_ok, locked;
    logic [12:0] wr_addr;
    logic [23:0] wr_data, frame_sig;

    dmd_video_capture #(
        .H_CELLS(HC), .V_CELLS(VC), .CELL(CL), .SAMPLE_OFS(OFS),
        .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .frame_sig(frame_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state (written only by the monitor)
    int          wr_total = 0, frame_wr = 0, mon_err = 0, done_cnt = 0, first_cyc = 0;
    logic [12:0] first_addr = 13'd0, last_addr = 13'd0, max_addr = 13'd0;
    logic [23:0] first_data = 24'h0, last_data = 24'h0, last_sig = 24'h0;
    logic        last_ok = 1'b0, last_locked = 1'b0, vs_pin_prev = 1'b0;
    // Driver state (written only by the main process)
    bit          chk_data = 1'b1;
    int          pix_cyc = 0, wr_at_rst = 0;

    function automatic logic [23:0] pix(input int x, input int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
        return {xb, yb, 8'hA5};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write/frame monitor, sampling away from the rising edge
    always @(negedge clk) begin
        if (vsync && !vs_pin_prev) begin
            frame_wr = 0;
            max_addr = 13'd0;
        end
        vs_pin_prev = vsync;
        if (wr_en) begin
            if (frame_wr == 0) begin
                first_cyc  = cyc;
                first_addr = wr_addr;
                first_data = wr_data;
            end
            last_addr = wr_addr;
            last_data = wr_data;
            if (int'(wr_addr) != frame_wr) mon_err++;
            if (chk_data && wr_data != pix((int'(wr_addr) % HC) * CL + OFS, (int'(wr_addr) / HC) * CL + OFS))
                mon_err++;
            if (wr_addr > max_addr) max_addr = wr_addr;
            frame_wr++;
            wr_total++;
        end
        if (frame_done) begin
            done_cnt++;
            last_ok     = frame_ok;
            last_locked = locked;
            last_sig    = frame_sig;
        end
    end

    task automatic run_frame(input bit do_vs, input int nlines, input int long_line,
                             input int rst_line, input bit konst, input int alt_x, input int alt_y);
        logic [23:0] p;
        chk_data = !konst;
        if (do_vs) begin
            vsync = 1'b1;
            repeat (2) @(negedge clk);
            vsync = 1'b0;
        end
        repeat (4) @(negedge clk);
        for (int y = 0; y < nlines; y++) begin
            if (y == rst_line) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_wr_en", wr_en, 0);
                check_eq("rst_wr_addr", wr_addr, 0);
                check_eq("rst_locked", locked, 0);
                check_eq("rst_frame_ok", frame_ok, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                wr_at_rst = wr_total;
            end
            hsync = 1'b1;
            @(negedge clk);
            hsync = 1'b0;
            repeat (2) @(negedge clk);
            for (int x = 0; x < ((y == long_line) ? HA + CL : HA); x++) begin
                p = konst ? 24'h123456 : pix(x, y);
                if (x == alt_x && y == alt_y) p = 24'h654321;
                if (x == OFS && y == OFS) pix_cyc = cyc;
                de = 1'b1;
                {red, green, blue} = p;
                @(negedge clk);
            end
            de = 1'b0;
            {red, green, blue} = 24'h000000;
            repeat (5) @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        {red, green, blue} = 24'h000000;
        repeat (3) @(negedge clk);
        check_eq("reset_wr_en", wr_en, 0);
        check_eq("reset_wr_data", wr_data, 0);
        check_eq("reset_frame_done", frame_done, 0);
        check_eq("reset_frame_sig", frame_sig, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_locked", locked, 0);

        // A: no vsync yet, nothing may be written
        run_frame(1'b0, VA, -1, -1, 1'b0, -1, -1);
        check_eq("A_writes", frame_wr, 0);

        // B: first captured frame
        d0 = done_cnt;
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("B_done", done_cnt - d0, 0);
        check_eq("B_writes", frame_wr, HC * VC);
        check_eq("B_first_addr", first_addr, 0);
        check_eq("B_first_data", first_data, 24'h0303A5);
        check_eq("B_latency", first_cyc - pix_cyc, 2);
        check_eq("B_last_addr", last_addr, HC * VC - 1);
        check_eq("B_last_data", last_data, 24'h1F0FA5);
        check_eq("B_seq", mon_err, 0);

        // C: reports B as good
        d0 = done_cnt;
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("C_done", done_cnt - d0, 1);
        check_eq("C_ok", last_ok, 1);
        check_eq("C_locked", last_locked, 1);
        check_eq("C_ok_held", frame_ok, 1);

        // D: one line short, last cell row never sampled
        run_frame(1'b1, VA - 1, -1, -1, 1'b0, -1, -1);
        check_eq("D_writes", frame_wr, HC * (VC - 1));

        // E: reports D as bad; contains a line one cell too long
        d0 = done_cnt;
        run_frame(1'b1, VA, 3, -1, 1'b0, -1, -1);
        check_eq("E_done", done_cnt - d0, 1);
        check_eq("E_ok", last_ok, 0);
        check_eq("E_locked", last_locked, 0);
        check_eq("E_writes", frame_wr, HC * VC);
        check_eq("E_max_addr", max_addr, HC * VC - 1);
        check_eq("E_seq", mon_err, 0);

        // F reports E (long line), G reports F (good)
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("F_ok", last_ok, 0);
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("G_ok", last_ok, 1);
        check_eq("G_locked", last_locked, 1);

        // H: reset mid-frame, then nothing until the next vsync
        run_frame(1'b1, VA, -1, 8, 1'b0, -1, -1);
        check_eq("H_post_rst_writes", wr_total - wr_at_rst, 0);

        // I: no frame_done for the discarded frame, full capture
        d0 = done_cnt;
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("I_done", done_cnt - d0, 0);
        check_eq("I_writes", frame_wr, HC * VC);

        // J: constant colour; reports I as good
        run_frame(1'b1, VA, -1, -1, 1'b1, -1, -1);
        check_eq("J_ok", last_ok, 1);
        check_eq("J_locked", last_locked, 1);
        // K: constant colour with one sampled pixel changed; reports J signature
        run_frame(1'b1, VA, -1, -1, 1'b1, OFS, OFS);
        check_eq("K_sig", last_sig, 24'h000000);
        d0 = done_cnt;
        run_frame(1'b1, VA, -1, -1, 1'b0, -1, -1);
        check_eq("L_done", done_cnt - d0, 1);
`ifdef DMD_CAPTURE_SIG_EN
        check_eq("L_sig", last_sig, 24'h123456 ^ 24'h654321);
`else
        check_eq("L_sig", last_sig, 24'h000000);
`endif
        check_eq("final_seq", mon_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
